// File: rtl/counter_prog_pkg.sv
// Shared mode codes for the programmable up/down counter.
package counter_prog_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'b00,
        CNT_ONESHOT = 2'b01,
        CNT_RELOAD  = 2'b10,
        CNT_BOUNCE  = 2'b11
    } cnt_mode_e;

endpackage

// File: rtl/counter_prog_term_detect.sv
// Effective limit and terminal-count detection for counter_prog.
module counter_term_detect #(
    parameter int unsigned BITS = 8
) (
    input  logic [BITS-1:0] count,
    input  logic [BITS-1:0] lim,
    input  logic            up,
    output logic [BITS-1:0] eff_lim,
    output logic            term
);

    // A programmed limit of zero stands for the full counter range.
    assign eff_lim = (lim == '0) ? '1 : lim;

    // Up: at or beyond the limit (out-of-range counts wrap on next step); down: at zero.
    assign term = up ? (count >= eff_lim) : (count == '0);

endmodule

// File: rtl/counter_prog.sv
// Runtime-programmable up/down counter with wrap, one-shot, auto-reload and bounce modes.
module counter_prog
    import counter_prog_pkg::*;
#(
    parameter int unsigned BITS     = 8,
    parameter int unsigned MAXVALUE = 0
) (
    input  logic            c,
    input  logic            clr,
    input  logic            en,
    input  logic            dir,
    input  logic [1:0]      mode,
    input  logic            ld,
    input  logic [BITS-1:0] in,
    input  logic            lim_we,
    input  logic [BITS-1:0] lim_in,
    output logic [BITS-1:0] out,
    output logic            ovf,
    output logic            done,
    output logic            updn
);

    localparam logic [BITS-1:0] LIM_RST = BITS'(MAXVALUE);
    localparam logic [BITS-1:0] ONE     = BITS'(1);

    logic [BITS-1:0] count;
    logic [BITS-1:0] rld;
    logic [BITS-1:0] lim;
    logic            bdir;

    logic [BITS-1:0] eff_lim;
    logic            term;
    logic            up;
    logic            bounce;
    cnt_mode_e       mode_e;

    logic [BITS-1:0] step_val;
    logic [BITS-1:0] nxt_count;
    logic            nxt_done;
    logic            nxt_bdir;

    assign mode_e = cnt_mode_e'(mode);
    assign bounce = (mode_e == CNT_BOUNCE);
    assign updn   = bounce ? bdir : dir;
    assign up     = ~updn;
    assign out    = count;

    counter_term_detect #(
        .BITS (BITS)
    ) u_term (
        .count   (count),
        .lim     (lim),
        .up      (up),
        .eff_lim (eff_lim),
        .term    (term)
    );

    // Terminal pulse for the cycle whose edge performs the terminal step.
    assign ovf = en & term & ~done & ~clr;

    // Next count/done/bounce-direction for an enabled step.
    always_comb begin
        step_val  = up ? (count + ONE) : (count - ONE);
        nxt_count = count;
        nxt_done  = done;
        nxt_bdir  = bdir;
        unique case (mode_e)
            CNT_WRAP: begin
                if (term) nxt_count = up ? '0 : eff_lim;
                else      nxt_count = step_val;
            end
            CNT_ONESHOT: begin
                if (term) nxt_done  = 1'b1;
                else      nxt_count = step_val;
            end
            CNT_RELOAD: begin
                if (term) nxt_count = rld;
                else      nxt_count = step_val;
            end
            CNT_BOUNCE: begin
                if (term && up) begin
                    nxt_count = count - ONE;
                    nxt_bdir  = 1'b1;
                end else if (term) begin
                    nxt_count = ONE;
                    nxt_bdir  = 1'b0;
                end else begin
                    nxt_count = step_val;
                end
            end
            default: ;
        endcase
    end

    // Register update: clr over ld over step; limit write runs alongside.
    always_ff @(posedge c) begin
        if (clr) begin
            count <= '0;
            rld   <= '0;
            lim   <= LIM_RST;
            done  <= 1'b0;
            bdir  <= 1'b0;
        end else begin
            if (lim_we) lim <= lim_in;
            if (ld) begin
                count <= in;
                rld   <= in;
                done  <= 1'b0;
                bdir  <= 1'b0;
            end else if (en && !done) begin
                count <= nxt_count;
                done  <= nxt_done;
                bdir  <= nxt_bdir;
            end
            if (!bounce) bdir <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_prog.sv
// Self-checking bench for counter_prog (BITS=4, MAXVALUE=0).
module tb_counter_prog;

    localparam int MAXV = 0;

    logic       c = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       ld = 1'b0;
    logic [3:0] din = 4'd0;
    logic       lim_we = 1'b0;
    logic [3:0] lim_in = 4'd0;
    logic [3:0] dout;
    logic       ovf;
    logic       done;
    logic       updn;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int m_count, m_rld, m_lim;
    bit m_done, m_bdir;

    counter_prog #(.BITS(4), .MAXVALUE(MAXV)) dut (
        .c(c), .clr(clr), .en(en), .dir(dir), .mode(mode), .ld(ld), .in(din),
        .lim_we(lim_we), .lim_in(lim_in), .out(dout), .ovf(ovf), .done(done), .updn(updn)
    );

    always #5 c = ~c;

    function automatic int eff_l();
        return (m_lim == 0) ? 15 : m_lim;
    endfunction

    function automatic bit going_up();
        return (mode == 2'd3) ? !m_bdir : !dir;
    endfunction

    function automatic bit at_term();
        return going_up() ? (m_count >= eff_l()) : (m_count == 0);
    endfunction

    function automatic bit model_ovf();
        return en && at_term() && !m_done && !clr;
    endfunction

    function automatic bit model_updn();
        return (mode == 2'd3) ? m_bdir : dir;
    endfunction

    // Advance the reference by one clock edge using the current inputs.
    function automatic void model_step();
        int  lv;
        bit  u, t;
        int  nlim;
        lv = eff_l();
        u  = going_up();
        t  = at_term();
        if (clr) begin
            m_count = 0; m_rld = 0; m_lim = MAXV; m_done = 0; m_bdir = 0;
            return;
        end
        nlim = lim_we ? int'(lim_in) : m_lim;
        if (ld) begin
            m_count = int'(din); m_rld = int'(din); m_done = 0; m_bdir = 0;
        end else if (en && !m_done) begin
            case (mode)
                2'd0: if (t) m_count = u ? 0 : lv; else m_count = u ? m_count + 1 : m_count - 1;
                2'd1: if (t) m_done = 1;           else m_count = u ? m_count + 1 : m_count - 1;
                2'd2: if (t) m_count = m_rld;      else m_count = u ? m_count + 1 : m_count - 1;
                default: begin
                    if (u && t)  begin m_count = m_count - 1; m_bdir = 1; end
                    else if (t)  begin m_count = 1; m_bdir = 0; end
                    else         m_count = u ? m_count + 1 : m_count - 1;
                end
            endcase
        end
        if (mode != 2'd3) m_bdir = 0;
        m_lim = nlim;
    endfunction

    task automatic tick();
        model_step();
        @(posedge c);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1; ld = 1'b0; en = 1'b0; lim_we = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic write_lim(input logic [3:0] v);
        lim_we = 1'b1; lim_in = v; en = 1'b0;
        tick();
        lim_we = 1'b0;
    endtask

    task automatic test_reset();
        mode = 2'd0; dir = 1'b1;
        do_clr();
        #1;
        n_checks++; if (dout !== 4'd0) begin $display("FAIL reset_out got %0d exp 0", dout); n_fail++; end
        n_checks++; if (done !== 1'b0) begin $display("FAIL reset_done got %0b exp 0", done); n_fail++; end
        n_checks++; if (updn !== 1'b1) begin $display("FAIL reset_updn got %0b exp 1", updn); n_fail++; end
        n_checks++; if (ovf !== 1'b0)  begin $display("FAIL reset_ovf got %0b exp 0", ovf); n_fail++; end
    endtask

    task automatic test_wrap();
        do_clr();
        mode = 2'd0; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_checks++; if (dout !== 4'(i)) begin $display("FAIL wrap_up_out i=%0d got %0d exp %0d", i, dout, i); n_fail++; end
            n_checks++; if (ovf !== (i == 15)) begin $display("FAIL wrap_up_ovf i=%0d got %0b exp %0b", i, ovf, i == 15); n_fail++; end
            tick();
        end
        n_checks++; if (dout !== 4'd0) begin $display("FAIL wrap_up_rollover got %0d exp 0", dout); n_fail++; end
        dir = 1'b1;
        #1;
        n_checks++; if (ovf !== 1'b1) begin $display("FAIL wrap_dn_ovf got %0b exp 1", ovf); n_fail++; end
        tick();
        n_checks++; if (dout !== 4'd15) begin $display("FAIL wrap_dn_out got %0d exp 15", dout); n_fail++; end
        tick();
        n_checks++; if (dout !== 4'd14) begin $display("FAIL wrap_dn_out2 got %0d exp 14", dout); n_fail++; end
    endtask

    task automatic test_limit();
        do_clr();
        mode = 2'd0; dir = 1'b0;
        write_lim(4'd5);
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            n_checks++; if (dout !== 4'(i % 6)) begin $display("FAIL lim5_out i=%0d got %0d exp %0d", i, dout, i % 6); n_fail++; end
            n_checks++; if (ovf !== (i % 6 == 5)) begin $display("FAIL lim5_ovf i=%0d got %0b exp %0b", i, ovf, i % 6 == 5); n_fail++; end
            tick();
        end
        repeat (4) tick();
        lim_we = 1'b1; lim_in = 4'd3;
        #1;
        n_checks++; if (dout !== 4'd5) begin $display("FAIL lim_change_pre got %0d exp 5", dout); n_fail++; end
        n_checks++; if (ovf !== 1'b1)  begin $display("FAIL lim_change_ovf got %0b exp 1", ovf); n_fail++; end
        tick();
        lim_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (dout !== 4'(i % 4)) begin $display("FAIL lim3_out i=%0d got %0d exp %0d", i, dout, i % 4); n_fail++; end
            n_checks++; if (ovf !== (i % 4 == 3)) begin $display("FAIL lim3_ovf i=%0d got %0b exp %0b", i, ovf, i % 4 == 3); n_fail++; end
            tick();
        end
    endtask

    task automatic test_oneshot();
        int exp_out[6]  = '{0, 1, 2, 3, 3, 3};
        bit exp_done[6] = '{0, 0, 0, 0, 1, 1};
        bit exp_ovf[6]  = '{0, 0, 0, 1, 0, 0};
        do_clr();
        mode = 2'd1; dir = 1'b0;
        write_lim(4'd3);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++; if (dout !== 4'(exp_out[i])) begin $display("FAIL os_out i=%0d got %0d exp %0d", i, dout, exp_out[i]); n_fail++; end
            n_checks++; if (done !== exp_done[i]) begin $display("FAIL os_done i=%0d got %0b exp %0b", i, done, exp_done[i]); n_fail++; end
            n_checks++; if (ovf !== exp_ovf[i]) begin $display("FAIL os_ovf i=%0d got %0b exp %0b", i, ovf, exp_ovf[i]); n_fail++; end
            tick();
        end
        ld = 1'b1; din = 4'd1;
        tick();
        ld = 1'b0;
        n_checks++; if (dout !== 4'd1) begin $display("FAIL os_reload_out got %0d exp 1", dout); n_fail++; end
        n_checks++; if (done !== 1'b0) begin $display("FAIL os_reload_done got %0b exp 0", done); n_fail++; end
        tick();
        n_checks++; if (dout !== 4'd2) begin $display("FAIL os_resume got %0d exp 2", dout); n_fail++; end
    endtask

    task automatic test_reload();
        int up_seq[6] = '{6, 7, 8, 9, 6, 7};
        int dn_seq[4] = '{2, 1, 0, 2};
        do_clr();
        mode = 2'd2; dir = 1'b0;
        write_lim(4'd9);
        ld = 1'b1; din = 4'd6;
        tick();
        ld = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++; if (dout !== 4'(up_seq[i])) begin $display("FAIL rl_up_out i=%0d got %0d exp %0d", i, dout, up_seq[i]); n_fail++; end
            n_checks++; if (ovf !== (up_seq[i] == 9)) begin $display("FAIL rl_up_ovf i=%0d got %0b exp %0b", i, ovf, up_seq[i] == 9); n_fail++; end
            tick();
        end
        dir = 1'b1; ld = 1'b1; din = 4'd2;
        tick();
        ld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (dout !== 4'(dn_seq[i])) begin $display("FAIL rl_dn_out i=%0d got %0d exp %0d", i, dout, dn_seq[i]); n_fail++; end
            n_checks++; if (ovf !== (i == 2)) begin $display("FAIL rl_dn_ovf i=%0d got %0b exp %0b", i, ovf, i == 2); n_fail++; end
            tick();
        end
    endtask

    task automatic test_bounce();
        int exp_out[8]  = '{0, 1, 2, 3, 2, 1, 0, 1};
        bit exp_ovf[8]  = '{0, 0, 0, 1, 0, 0, 1, 0};
        bit exp_updn[8] = '{0, 0, 0, 0, 1, 1, 1, 0};
        do_clr();
        mode = 2'd3;
        write_lim(4'd3);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dir = 1'($urandom_range(0, 1));
            #1;
            n_checks++; if (dout !== 4'(exp_out[i])) begin $display("FAIL bn_out i=%0d got %0d exp %0d", i, dout, exp_out[i]); n_fail++; end
            n_checks++; if (ovf !== exp_ovf[i]) begin $display("FAIL bn_ovf i=%0d got %0b exp %0b", i, ovf, exp_ovf[i]); n_fail++; end
            n_checks++; if (updn !== exp_updn[i]) begin $display("FAIL bn_updn i=%0d got %0b exp %0b", i, updn, exp_updn[i]); n_fail++; end
            tick();
        end
    endtask

    task automatic test_clr_midcount();
        do_clr();
        mode = 2'd0; dir = 1'b0;
        write_lim(4'd5);
        en = 1'b1;
        repeat (5) tick();
        clr = 1'b1; ld = 1'b1; din = 4'd7; lim_we = 1'b1; lim_in = 4'd2;
        #1;
        n_checks++; if (ovf !== 1'b0) begin $display("FAIL clr_ovf_mask got %0b exp 0", ovf); n_fail++; end
        tick();
        clr = 1'b0; ld = 1'b0; lim_we = 1'b0;
        n_checks++; if (dout !== 4'd0) begin $display("FAIL clr_out got %0d exp 0", dout); n_fail++; end
        n_checks++; if (done !== 1'b0) begin $display("FAIL clr_done got %0b exp 0", done); n_fail++; end
        repeat (7) tick();
        n_checks++; if (dout !== 4'd7) begin $display("FAIL clr_lim_restored got %0d exp 7", dout); n_fail++; end
    endtask

    task automatic test_random();
        do_clr();
        for (int i = 0; i < 600; i++) begin
            clr    = ($urandom_range(0, 99) < 3);
            ld     = ($urandom_range(0, 99) < 8);
            lim_we = ($urandom_range(0, 99) < 8);
            en     = ($urandom_range(0, 99) < 80);
            dir    = 1'($urandom_range(0, 1));
            mode   = ($urandom_range(0, 99) < 10) ? 2'($urandom_range(0, 3)) : mode;
            din    = 4'($urandom_range(0, 15));
            lim_in = 4'($urandom_range(0, 15));
            #1;
            n_checks++; if (ovf !== model_ovf()) begin $display("FAIL rnd_ovf i=%0d got %0b exp %0b", i, ovf, model_ovf()); n_fail++; end
            n_checks++; if (updn !== model_updn()) begin $display("FAIL rnd_updn i=%0d got %0b exp %0b", i, updn, model_updn()); n_fail++; end
            tick();
            n_checks++; if (dout !== 4'(m_count)) begin $display("FAIL rnd_out i=%0d got %0d exp %0d", i, dout, m_count); n_fail++; end
            n_checks++; if (done !== m_done) begin $display("FAIL rnd_done i=%0d got %0b exp %0b", i, done, m_done); n_fail++; end
        end
        clr = 1'b0; ld = 1'b0; lim_we = 1'b0;
    endtask

    initial begin
        m_count = 0; m_rld = 0; m_lim = MAXV; m_done = 0; m_bdir = 0;
        test_reset();
        test_wrap();
        test_limit();
        test_oneshot();
        test_reload();
        test_bounce();
        test_clr_midcount();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
